// File: rtl/bpsk_rx_ber_pkg.sv
// Shared definitions for the BPSK receiver BER checker: PRBS9 taps, window length,
// FSM encoding and default datapath sizing.
package bpsk_rx_ber_pkg;

  localparam int unsigned PrbsLen   = 9;
  localparam int unsigned PrbsTapHi = 8;
  localparam int unsigned PrbsTapLo = 4;
  localparam int unsigned WinLen    = 511;
  localparam int unsigned WinW      = 9;

  localparam int unsigned DefOs     = 4;
  localparam int unsigned DefNbData = 8;

  typedef enum logic [1:0] {
    StFill   = 2'd0,
    StCheck  = 2'd1,
    StLocked = 2'd2
  } state_e;

endpackage

// File: rtl/bpsk_rx_ber_prbs9_predictor.sv
// PRBS9 reference register: loads received bits while filling, otherwise free-runs on its own
// prediction. s[0] is the newest bit.
module prbs9_predictor
  import bpsk_rx_ber_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic load_i,
  input  logic rx_bit_i,
  output logic p_o,
  output logic zero_next_o
);

  logic [PrbsLen-1:0] s_q, s_d;

  always_comb begin
    p_o         = s_q[PrbsTapHi] ^ s_q[PrbsTapLo];
    // Loading rx now would leave an all-zero register, which can never predict anything useful.
    zero_next_o = ({s_q[PrbsLen-2:0], rx_bit_i} == '0);
    s_d         = s_q;
    if (en_i) begin
      s_d = {s_q[PrbsLen-2:0], load_i ? rx_bit_i : p_o};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/bpsk_rx_ber.sv
// BPSK hard-decision receiver with PRBS9 lock detection and saturating bit/error counters.
module bpsk_rx_ber
  import bpsk_rx_ber_pkg::*;
#(
  parameter int unsigned OS      = DefOs,
  parameter int unsigned NB_DATA = DefNbData,
  parameter int unsigned NB_CNT  = 32,
  parameter int unsigned ERR_TH  = 8
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [1:0]        i_phase,
  output logic              o_locked,
  output logic              o_ber_zero,
  output logic [NB_CNT-1:0] o_bit_count,
  output logic [NB_CNT-1:0] o_err_count
);

  localparam int unsigned PhW = (OS > 1) ? $clog2(OS) : 1;

  logic [PhW-1:0]    ph_q, ph_d;
  logic [1:0]        phase_q, phase_d;
  state_e            state_q, state_d;
  logic [3:0]        fill_q, fill_d;
  logic [WinW-1:0]   win_q, win_d, werr_q, werr_d, werr_inc;
  logic [NB_CNT-1:0] bit_q, bit_d, err_q, err_d;
  logic              locked_q, locked_d, ber_zero_q, ber_zero_d;

  logic strobe, phase_chg, rx_bit, pred_bit, mismatch, zero_next, win_end;
  logic unused_data;

  assign unused_data = ^i_data[NB_DATA-2:0];
  assign rx_bit      = ~i_data[NB_DATA-1];
  assign strobe      = i_enable && (32'(ph_q) == 32'(i_phase));
  assign phase_chg   = i_enable && (i_phase != phase_q) && (state_q != StFill);
  assign mismatch    = rx_bit ^ pred_bit;
  assign werr_inc    = werr_q + WinW'(mismatch);
  assign win_end     = (32'(win_q) == WinLen - 1);

  prbs9_predictor u_pred (
    .clk_i       (clock),
    .rst_ni      (i_reset),
    .en_i        (strobe && !phase_chg),
    .load_i      (state_q == StFill),
    .rx_bit_i    (rx_bit),
    .p_o         (pred_bit),
    .zero_next_o (zero_next)
  );

  always_comb begin
    ph_d     = ph_q;
    phase_d  = phase_q;
    state_d  = state_q;
    fill_d   = fill_q;
    win_d    = win_q;
    werr_d   = werr_q;
    bit_d    = bit_q;
    err_d    = err_q;
    locked_d = locked_q;

    if (i_enable) begin
      ph_d    = (32'(ph_q) == OS - 1) ? '0 : ph_q + PhW'(1);
      phase_d = i_phase;
    end

    // A phase move invalidates the alignment; totals survive so the host can still read them.
    if (phase_chg) begin
      state_d  = StFill;
      fill_d   = '0;
      win_d    = '0;
      werr_d   = '0;
      locked_d = 1'b0;
    end else if (strobe) begin
      unique case (state_q)
        StFill: begin
          if (32'(fill_q) == PrbsLen - 1) begin
            fill_d  = '0;
            win_d   = '0;
            werr_d  = '0;
            state_d = zero_next ? StFill : StCheck;
          end else begin
            fill_d = fill_q + 4'd1;
          end
        end
        StCheck: begin
          win_d  = win_q + WinW'(1);
          werr_d = werr_inc;
          if (win_end) begin
            win_d  = '0;
            werr_d = '0;
            if (32'(werr_inc) <= ERR_TH) begin
              state_d  = StLocked;
              bit_d    = '0;
              err_d    = '0;
              locked_d = 1'b1;
            end else begin
              state_d = StFill;
            end
          end
        end
        StLocked: begin
          bit_d  = (bit_q == '1) ? bit_q : bit_q + NB_CNT'(1);
          win_d  = win_q + WinW'(1);
          werr_d = werr_inc;
          if (mismatch && (err_q != '1)) begin
            err_d = err_q + NB_CNT'(1);
          end
          if (win_end) begin
            win_d  = '0;
            werr_d = '0;
            if (32'(werr_inc) > ERR_TH) begin
              state_d  = StFill;
              locked_d = 1'b0;
            end
          end
        end
        default: state_d = StFill;
      endcase
    end

    ber_zero_d = locked_d && (err_d == '0);
  end

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      ph_q       <= '0;
      phase_q    <= '0;
      state_q    <= StFill;
      fill_q     <= '0;
      win_q      <= '0;
      werr_q     <= '0;
      bit_q      <= '0;
      err_q      <= '0;
      locked_q   <= 1'b0;
      ber_zero_q <= 1'b0;
    end else begin
      ph_q       <= ph_d;
      phase_q    <= phase_d;
      state_q    <= state_d;
      fill_q     <= fill_d;
      win_q      <= win_d;
      werr_q     <= werr_d;
      bit_q      <= bit_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
      ber_zero_q <= ber_zero_d;
    end
  end

  assign o_locked    = locked_q;
  assign o_ber_zero  = ber_zero_q;
  assign o_bit_count = bit_q;
  assign o_err_count = err_q;

endmodule

// File: doc/bpsk_rx_ber.md
BPSK_RX_BER -- requirements
Module: bpsk_rx_ber

Interface
REQ-001 Parameter OS, default 4: oversampling factor; input samples per symbol.
REQ-002 Parameter NB_DATA, default 8: width of the signed input sample.
REQ-003 Parameter NB_CNT, default 32: width of the bit and error counters.
REQ-004 Parameter ERR_TH, default 8: maximum errors allowed in one 511-symbol window while keeping lock.
REQ-005 Port clock, input, 1: system clock; all logic on rising edge.
REQ-006 Port i_reset, input, 1: synchronous, active-low reset (reset when i_reset==0 at a rising edge).
REQ-007 Port i_enable, input, 1: RX enable; when low, all state holds.
REQ-008 Port i_data, input, NB_DATA: signed two's-complement RC-filter output, one sample per clock.
REQ-009 Port i_phase, input, 2: sampling offset within the symbol, 0..OS-1.
REQ-010 Port o_locked, output, 1: checker aligned to received PRBS9.
REQ-011 Port o_ber_zero, output, 1: o_locked AND o_err_count==0.
REQ-012 Port o_bit_count, output, NB_CNT: symbols compared since lock.
REQ-013 Port o_err_count, output, NB_CNT: mismatches since lock.

Function
REQ-014 Phase counter ph counts 0..OS-1 and wraps, advancing only when i_enable=1.
REQ-015 Strobe = i_enable AND (ph == i_phase); exactly one strobe per OS enabled cycles.
REQ-016 Slicer: rx_bit = NOT i_data[NB_DATA-1], so sample >= 0 gives 1 and negative gives 0, matching TX mapping 1->+1, 0->-1.
REQ-017 Reference register s[8:0], with s[0] the newest bit; predicted bit p = s[8] XOR s[4] (PRBS9, x^9+x^5+1).
REQ-018 FSM states: FILL, CHECK, LOCKED; all transitions and actions occur only on a strobe.
REQ-019 FILL: shift rx_bit into s. After 9 strobes, go to CHECK with the window counter and window error counter cleared.
REQ-020 CHECK: compare rx_bit with p and shift p (not rx_bit) into s. Count window mismatches. After 511 strobes, go to LOCKED if mismatches <= ERR_TH; otherwise go to FILL.
REQ-021 Entering LOCKED clears o_bit_count and o_err_count and restarts the window.
REQ-022 LOCKED: shift p into s (free-running). Each strobe increments o_bit_count; a mismatch also increments o_err_count.
REQ-023 LOCKED: at each 511-strobe window end, window mismatches > ERR_TH sends the FSM to FILL, and o_locked drops. Counters then hold their values.
REQ-024 Counters saturate at all-ones; they never wrap.
REQ-025 Latency: counter and o_locked updates are visible on the clock edge following the strobe cycle, with registered outputs.
REQ-026 A change of i_phase while not in FILL forces FILL on the next cycle; the window counters are cleared and the totals hold.
REQ-027 i_enable=0: ph, s, FSM and counters all hold; outputs are unchanged.
REQ-028 s must never stay all-zero in CHECK or LOCKED; an all-zero s at CHECK entry forces FILL.

Reset
REQ-029 On i_reset==0 at a clock edge: ph=0, s=0, FSM=FILL, all counters cleared, o_locked=0, o_ber_zero=0, o_bit_count=0, o_err_count=0.
REQ-030 Reset overrides i_enable and is honored mid-window in any state.

Structure
REQ-031 A shared include file (rx_defs.vh) SHALL hold: the PRBS9 tap positions (8, 4), window length 511, the FSM state encodings, and the default OS/NB_DATA.
REQ-032 One sub-module, prbs9_predictor, SHALL implement s plus p, with load-from-rx and free-run modes.

Verification
REQ-033 Clean PRBS9 (seed 0x1AA), OS=4, i_phase=2, ideal +/-64 samples -> o_locked=1 after 9+511 strobes (2080 enabled cycles), o_err_count stays 0, o_ber_zero=1.
REQ-034 Same stream with 3 bit flips injected after lock -> o_err_count=3, o_locked stays 1, o_ber_zero=0.
REQ-035 Random bits (not PRBS9) -> o_locked never asserts over 10 windows; the FSM cycles FILL->CHECK->FILL.
REQ-036 Locked, then i_phase changed 2->0 -> FILL next cycle, o_locked=0; relock within 520 strobes; counters cleared at relock.
REQ-037 i_enable low for 100 cycles mid-LOCKED -> o_bit_count is unchanged across the gap; no errors are added on resume.
REQ-038 i_reset=0 for one cycle mid-CHECK -> all outputs are 0 on the next edge and the FSM is in FILL.
